// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: state codes,
// opcodes, funct codes, ALU control codes and the ALU-op selector.
package mc_ctrl_pkg;

  localparam int OP_W     = 6;
  localparam int FUNCT_W  = 6;
  localparam int ALUCTL_W = 3;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXECUTE = 4'd6;
  localparam state_t S_ALUWB   = 4'd7;
  localparam state_t S_BRANCH  = 4'd8;
  localparam state_t S_ADDIEX  = 4'd9;
  localparam state_t S_ADDIWB  = 4'd10;
  localparam state_t S_JUMP    = 4'd11;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the controller's ALU-op and the funct field
// to the 3-bit ALU control code, flagging funct values outside the subset.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0]          aluop,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                funct_illegal
);

  // ALU code select; funct is only consulted for R-type execution
  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: begin
            alu_control   = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset Moore controller. Optional macro MC_CTRL_JUMP_EN
// builds the JUMP state; without it opcode j decodes as illegal.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                illegal_op
);

  state_t state_r;
  state_t next_state_s;
  aluop_t aluop_s;
  logic   pc_write_s, branch_s, mem_write_s, ir_write_s, reg_write_s;
  logic   op_illegal_s, funct_illegal_s;

  alu_decoder u_alu_decoder (
    .aluop         (aluop_s),
    .funct         (funct),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal_s)
  );

  // State register; async reset lands in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_FETCH;
    else        state_r <= next_state_s;
  end

  // Next-state and per-state Moore output decode
  always_comb begin
    next_state_s = S_FETCH;
    aluop_s      = ALUOP_ADD;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    op_illegal_s = 1'b0;
    iord         = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        alu_src_b    = 2'b01;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXECUTE;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         next_state_s = S_JUMP;
`endif
          default: begin
            op_illegal_s = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        next_state_s = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord         = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a    = 1'b1;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = funct_illegal_s ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop_s   = ALUOP_SUB;
        pc_src    = 2'b01;
        branch_s  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: reg_write_s = 1'b1;
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_s = 1'b1;
      end
`endif
      default: next_state_s = S_FETCH;
    endcase
  end

  // Side-effecting strobes are held off for the whole reset assertion
  assign pc_en      = rst_n & (pc_write_s | (branch_s & zero));
  assign ir_write   = rst_n & ir_write_s;
  assign mem_write  = rst_n & mem_write_s;
  assign reg_write  = rst_n & reg_write_s;
  assign illegal_op = rst_n & (op_illegal_s |
                               ((state_r == S_EXECUTE) & funct_illegal_s));

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: directed and random instructions compared cycle by
// cycle against an instruction-level model of the controller's strobes.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       illegal_op;

  int n_vec = 0;
  int n_err = 0;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pack(logic pe, logic io, logic mw, logic iw, logic rw,
                                       logic rd, logic mr, logic sa, logic [1:0] sb,
                                       logic [1:0] ps, logic [2:0] ac, logic il);
    return {pe, io, mw, iw, rw, rd, mr, sa, sb, ps, ac, il};
  endfunction

  function automatic logic [15:0] observed();
    return pack(pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, pc_src, alu_control, illegal_op);
  endfunction

  // {valid, alu code} for an R-type funct field
  function automatic logic [3:0] funct_alu(logic [5:0] f);
    case (f)
      6'h20:   return {1'b1, 3'b000};
      6'h22:   return {1'b1, 3'b001};
      6'h24:   return {1'b1, 3'b010};
      6'h25:   return {1'b1, 3'b011};
      6'h2a:   return {1'b1, 3'b101};
      default: return {1'b0, 3'b000};
    endcase
  endfunction

  // Expected strobes for one named phase of an instruction
  function automatic logic [15:0] phase_vec(string ph, logic z, logic [2:0] rcode);
    case (ph)
      "fetch":      return pack(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0);
      "decode":     return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b000,1'b0);
      "decode_bad": return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b000,1'b1);
      "memaddr":    return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b000,1'b0);
      "memread":    return pack(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0);
      "memwb":      return pack(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0);
      "memwrite":   return pack(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0);
      "exec":       return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,rcode,1'b0);
      "exec_bad":   return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,1'b1);
      "aluwb":      return pack(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0);
      "branch":     return pack(z,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b001,1'b0);
      "addiex":     return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b000,1'b0);
      "addiwb":     return pack(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0);
      "jump":       return pack(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0);
      default:      return 16'hffff;
    endcase
  endfunction

  // Phase list an instruction walks through, from opcode and funct alone
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, output string q[$]);
    logic [3:0] fa;
    fa = funct_alu(fn);
    q = {"fetch"};
    case (op)
      6'b100011: q = {q, "decode", "memaddr", "memread", "memwb"};
      6'b101011: q = {q, "decode", "memaddr", "memwrite"};
      6'b000000: if (fa[3]) q = {q, "decode", "exec", "aluwb"};
                 else       q = {q, "decode", "exec_bad"};
      6'b000100: q = {q, "decode", "branch"};
      6'b001000: q = {q, "decode", "addiex", "addiwb"};
`ifdef MC_CTRL_JUMP_EN
      6'b000010: q = {q, "decode", "jump"};
`endif
      default:   q = {q, "decode_bad"};
    endcase
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Runs one instruction from a FETCH cycle start; zmode<0 randomises zero
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
    string q[$];
    logic [3:0] fa;
    plan(op, fn, q);
    fa = funct_alu(fn);
    opcode = op;
    funct  = fn;
    foreach (q[i]) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      check($sformatf("op%b_fn%b_c%0d_%s", op, fn, i + 1, q[i]), observed(),
            phase_vec(q[i], zero, fa[2:0]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] reset_vec;
    reset_vec = pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0);
    rst_n = 1'b0; zero = 1'b1; opcode = 6'b101011; funct = 6'h00;
    #3;
    check("in_reset", observed(), reset_vec);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(6'b100011, 6'h00, -1);   // lw
    run_instr(6'b000000, 6'h2a, -1);   // slt
    run_instr(6'b000100, 6'h00, 1);    // beq taken
    run_instr(6'b000100, 6'h00, 0);    // beq not taken
    run_instr(6'b111111, 6'h20, -1);   // illegal opcode
    run_instr(6'b000000, 6'h07, -1);   // illegal funct
    run_instr(6'b000010, 6'h00, -1);   // j
    run_instr(6'b001000, 6'h00, -1);   // addi

    // Reset in the middle of a store's memory-write cycle
    opcode = 6'b101011; funct = 6'h00;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("memwr_before_reset", {15'd0, mem_write}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check("memwr_during_reset", observed(), reset_vec);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(6'b101011, 6'h00, -1);   // first cycle after release is FETCH

    for (int k = 0; k < 80; k++) begin
      logic [5:0] op, fn;
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h2a;
        default: fn = 6'($urandom);
      endcase
      run_instr(op, fn, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
